mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles in an access state before forced abort (range 1..255).
REQ-002 Port: CLK  input  1  system clock, all state updates on rising edge.
REQ-003 Port: nRST  input  1  asynchronous active-low reset.
REQ-004 Port: iREN  input  1  instruction fetch request, held by requester until ihit.
REQ-005 Port: iaddr  input  32  instruction word address.
REQ-006 Port: dREN  input  1  data load request, held until dhit.
REQ-007 Port: dWEN  input  1  data store request, held until dhit.
REQ-008 Port: daddr  input  32  data address.
REQ-009 Port: dstore  input  32  store data.
REQ-010 Port: ramload  input  32  RAM read data, valid when ram_ready=1.
REQ-011 Port: ram_ready  input  1  RAM completes the current access this cycle.
REQ-012 Port: ramREN, ramWEN  output  1 each  RAM read/write strobes.
REQ-013 Port: ramaddr, ramstore  output  32 each  RAM address and write data.
REQ-014 Port: ihit, dhit  output  1 each  single-cycle completion pulses.
REQ-015 Port: iload, dload  output  32 each  returned read data.
REQ-016 Port: memerr  output  1  single-cycle pulse on timeout abort.

Function
REQ-017 FSM states SHALL be IDLE, IACC, DACC; registered state, registered last-grant flag (LG: 0=instr, 1=data), 8-bit wait counter.
REQ-018 IDLE: only iREN -> IACC; only dREN|dWEN -> DACC; both -> grant side opposite LG; none -> stay IDLE.
REQ-019 Entering IACC/DACC SHALL update LG to the granted side and clear the counter.
REQ-020 IDLE SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
REQ-021 IACC: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
REQ-022 DACC: ramaddr=daddr, ramstore=dstore; dWEN=1 -> ramWEN=1, ramREN=0 (write wins over read when both set); else ramREN=1, ramWEN=0.
REQ-023 In IACC with ram_ready=1: ihit=1 and iload=ramload same cycle (combinational); next state IDLE.
REQ-024 In DACC with ram_ready=1: dhit=1; dload=ramload for a read, dload=0 for a write; next state IDLE.
REQ-025 iload/dload SHALL be 0 whenever the corresponding hit is 0.
REQ-026 Counter increments each cycle in IACC/DACC with ram_ready=0; when counter==TIMEOUT-1 and ram_ready=0, the arbiter SHALL pulse memerr=1 plus the active side's hit, load data=0, and return to IDLE.
REQ-027 ram_ready=1 on the timeout cycle SHALL complete normally with memerr=0.
REQ-028 Minimum access latency: grant cycle+1 (IDLE cycle, then access cycle with ram_ready); back-to-back accesses SHALL always pass through one IDLE cycle.
REQ-029 Requester deasserting its request mid-access SHALL NOT abort; access completes and hit still pulses.
REQ-030 ram_ready in IDLE SHALL be ignored; no hit, no memerr.
REQ-031 Counter SHALL NOT wrap; it saturates at TIMEOUT-1 until state leaves.

Reset
REQ-032 nRST=0 SHALL immediately force state=IDLE, LG=0 (so data wins first contention), counter=0, all outputs 0, independent of CLK.
REQ-033 Reset asserted mid-access SHALL drop ramREN/ramWEN in the same cycle with no hit or memerr pulse; after release, pending requests re-arbitrate from IDLE.

Verification
REQ-034 Reset release, iREN=1, iaddr=0x40, ram_ready=1 in cycle 2 -> ramREN=1 ramaddr=0x40 in cycle 2, ihit=1 iload=ramload=0x8C220004 that cycle, IDLE next.
REQ-035 iREN=dREN=1 after reset -> DACC first (dhit), then IDLE, then IACC (ihit); repeated contention alternates D,I,D,I.
REQ-036 dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1 ramREN=0 ramstore=0xDEADBEEF; dhit with dload=0 on ram_ready.
REQ-037 TIMEOUT=15, iREN=1, ram_ready held 0 -> memerr=1 and ihit=1 with iload=0 in 15th IACC cycle, then IDLE; ram_ready=1 on exactly 15th cycle -> normal hit, memerr=0.
REQ-038 nRST pulsed low during third DACC cycle -> ramWEN/ramREN 0 immediately, no dhit; after release, held dREN re-granted and completes.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch vs. data load/store onto one RAM port.
// Alternating priority under contention, with an access timeout that aborts via memerr.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        memerr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       lg, lg_nxt;       // last grant: 0 = instruction, 1 = data
  logic [7:0] cnt, cnt_nxt;
  logic       d_req;
  logic       expired;

  assign d_req   = dREN | dWEN;
  assign expired = (cnt == CNT_LAST) && !ram_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      lg    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      lg    <= lg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    lg_nxt    = lg;
    cnt_nxt   = cnt;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ihit      = 1'b0;
    dhit      = 1'b0;
    iload     = '0;
    dload     = '0;
    memerr    = 1'b0;

    unique case (state)
      IDLE: begin
        // Contention goes to the side that was not served last.
        if (iREN && d_req) begin
          state_nxt = lg ? IACC : DACC;
          lg_nxt    = ~lg;
          cnt_nxt   = '0;
        end else if (iREN) begin
          state_nxt = IACC;
          lg_nxt    = 1'b0;
          cnt_nxt   = '0;
        end else if (d_req) begin
          state_nxt = DACC;
          lg_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end

      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ram_ready) begin
          ihit      = 1'b1;
          iload     = ramload;
          state_nxt = IDLE;
        end else if (expired) begin
          ihit      = 1'b1;
          memerr    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
        if (ram_ready) begin
          dhit      = 1'b1;
          dload     = dWEN ? 32'd0 : ramload;
          state_nxt = IDLE;
        end else if (expired) begin
          dhit      = 1'b1;
          memerr    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
